// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: EX operand forwarding, ID branch-compare forwarding,
// load-use / branch-on-load / long-op scoreboard hazard detection.
// Optional macro FWD_PERF_CNT_EN adds saturating stall performance counters.
module fwd_hazard_scoreboard #(
    parameter int RA_W     = 5,
    parameter int LONG_MAX = 4,
    parameter int CNT_W    = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              id_valid,
    input  logic [RA_W-1:0]                   id_rs1,
    input  logic [RA_W-1:0]                   id_rs2,
    input  logic                              id_use_rs1,
    input  logic                              id_use_rs2,
    input  logic [RA_W-1:0]                   id_rd,
    input  logic                              id_reg_write,
    input  logic                              id_is_branch,
    input  logic                              id_is_long,
    input  logic [RA_W-1:0]                   ex_rs1,
    input  logic [RA_W-1:0]                   ex_rs2,
    input  logic [RA_W-1:0]                   ex_rd,
    input  logic                              ex_reg_write,
    input  logic                              ex_is_load,
    input  logic                              ex_is_long,
    input  logic [RA_W-1:0]                   mem_rd,
    input  logic                              mem_reg_write,
    input  logic                              mem_is_load,
    input  logic [RA_W-1:0]                   wb_rd,
    input  logic                              wb_reg_write,
    input  logic                              long_done,
    input  logic [RA_W-1:0]                   long_rd,
    input  logic                              flush,
    output logic [1:0]                        fwd_a,
    output logic [1:0]                        fwd_b,
    output logic [1:0]                        fwd_br1,
    output logic [1:0]                        fwd_br2,
    output logic                              stall_id,
    output logic [$clog2(LONG_MAX+1)-1:0]     sb_busy,
    output logic                              sb_err
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                  perf_stall_cyc,
    output logic [CNT_W-1:0]                  perf_lu_stall,
    output logic [CNT_W-1:0]                  perf_sb_stall
`endif
);

    localparam int BUSY_W = $clog2(LONG_MAX + 1);
    localparam int NREG   = 2 ** RA_W;
    localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(LONG_MAX);
    localparam logic [RA_W-1:0]   R0       = '0;

    logic [NREG-1:0]   sb_q, sb_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    logic              err_q, err_d;

    logic id_ok, use1, use2;
    logic ex_ld_m, mem_ld_m, lu_haz, bl_haz, raw_haz, waw_haz, full_haz;
    logic lu_cause, sb_cause;
    logic set_en, clr_en;

    // EX operand forwarding: EX_MEM result has priority over MEM_WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && mem_rd != R0 && mem_rd == ex_rs1)    fwd_a = 2'b10;
        else if (wb_reg_write && wb_rd != R0 && wb_rd == ex_rs1)  fwd_a = 2'b01;
        if (mem_reg_write && mem_rd != R0 && mem_rd == ex_rs2)    fwd_b = 2'b10;
        else if (wb_reg_write && wb_rd != R0 && wb_rd == ex_rs2)  fwd_b = 2'b01;
    end

    // Branch-compare forwarding in ID; loads cannot be forwarded from EX or MEM
    always_comb begin
        fwd_br1 = 2'b00;
        fwd_br2 = 2'b00;
        if (id_is_branch) begin
            if (ex_reg_write && ex_rd != R0 && !ex_is_load && ex_rd == id_rs1)          fwd_br1 = 2'b01;
            else if (mem_reg_write && mem_rd != R0 && !mem_is_load && mem_rd == id_rs1) fwd_br1 = 2'b10;
            if (ex_reg_write && ex_rd != R0 && !ex_is_load && ex_rd == id_rs2)          fwd_br2 = 2'b01;
            else if (mem_reg_write && mem_rd != R0 && !mem_is_load && mem_rd == id_rs2) fwd_br2 = 2'b10;
        end
    end

    // Hazard terms; stall is forced low during reset and on flush
    always_comb begin
        id_ok    = id_valid && !flush && rst_n;
        use1     = id_use_rs1 && id_rs1 != R0;
        use2     = id_use_rs2 && id_rs2 != R0;
        ex_ld_m  = ex_is_load && ex_reg_write && ex_rd != R0 &&
                   ((use1 && ex_rd == id_rs1) || (use2 && ex_rd == id_rs2));
        mem_ld_m = mem_is_load && mem_reg_write && mem_rd != R0 &&
                   ((use1 && mem_rd == id_rs1) || (use2 && mem_rd == id_rs2));
        lu_haz   = ex_ld_m;
        bl_haz   = id_is_branch && (ex_ld_m || mem_ld_m);
        raw_haz  = (use1 && sb_q[id_rs1]) || (use2 && sb_q[id_rs2]);
        waw_haz  = id_reg_write && id_rd != R0 && sb_q[id_rd];
        full_haz = id_is_long && busy_q == BUSY_MAX;
        lu_cause = id_ok && (lu_haz || bl_haz);
        sb_cause = id_ok && (raw_haz || waw_haz || full_haz);
        stall_id = lu_cause || sb_cause;
    end

    // Scoreboard next state: set on long issue from EX, clear on long writeback
    always_comb begin
        sb_d   = sb_q;
        busy_d = busy_q;
        err_d  = err_q;
        set_en = ex_is_long && ex_reg_write && ex_rd != R0;
        clr_en = long_done && long_rd != R0 && sb_q[long_rd];
        if (long_done && long_rd != R0 && !sb_q[long_rd]) err_d = 1'b1;
        if (clr_en) sb_d[long_rd] = 1'b0;
        if (set_en) sb_d[ex_rd]   = 1'b1;
        if (set_en && !clr_en) begin
            if (busy_q != BUSY_MAX) busy_d = busy_q + 1'b1;
        end else if (clr_en && !set_en) begin
            busy_d = busy_q - 1'b1;
        end
    end

    // Scoreboard state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign sb_busy = busy_q;
    assign sb_err  = err_q;

`ifdef FWD_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    logic [CNT_W-1:0] stall_cyc_q, lu_cnt_q, sb_cnt_q;

    // Saturating stall counters, split by hazard cause
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cyc_q <= '0;
            lu_cnt_q    <= '0;
            sb_cnt_q    <= '0;
        end else begin
            stall_cyc_q <= sat_inc(stall_cyc_q, stall_id);
            lu_cnt_q    <= sat_inc(lu_cnt_q, lu_cause);
            sb_cnt_q    <= sat_inc(sb_cnt_q, sb_cause);
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_lu_stall  = lu_cnt_q;
    assign perf_sb_stall  = sb_cnt_q;
`endif

endmodule
